// File: rtl/mx_int8_block_packer.sv
// mx_int8_block_packer: serial int8 stream -> parallel MXINT8 block (scale + elements).
// One fill buffer plus one output register, so a new block fills while the
// previous one waits for the consumer.
// Optional: define MXINT8_PACK_NAN_FLAG_EN to add the out_nan flag.

// Per-element slot: one fill-buffer entry and its output register.
module mx_int8_pack_lane #(
  parameter int ELEM_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic              xfer,
  input  logic [ELEM_W-1:0] din,
  output logic [ELEM_W-1:0] q
);
  logic [ELEM_W-1:0] fbuf;

  // Fill entry: cleared on transfer so unwritten slots of a short block read 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       fbuf <= '0;
    else if (xfer) fbuf <= '0;
    else if (wr)   fbuf <= din;
  end

  // Output entry: loaded only on transfer, otherwise held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       q <= '0;
    else if (xfer) q <= fbuf;
  end
endmodule

module mx_int8_block_packer #(
  parameter int BLOCK_SIZE = 32,
  parameter int ELEM_W     = 8,
  parameter int SCALE_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ELEM_W-1:0]  in_data,
  input  logic [SCALE_W-1:0] in_scale,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SCALE_W-1:0] scale_out,
  output logic [ELEM_W-1:0]  elements_out [BLOCK_SIZE-1:0]
`ifdef MXINT8_PACK_NAN_FLAG_EN
  ,
  output logic               out_nan
`endif
);
  localparam int CW = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(BLOCK_SIZE - 1);

  logic [CW-1:0]      fcnt;
  logic               fdone;
  logic [SCALE_W-1:0] fscale;
  logic               accept;
  logic               xfer;
  logic               blk_end;

  assign in_ready = !fdone;
  assign accept   = in_valid && !fdone;
  // Output slot is free or being drained this edge.
  assign xfer     = fdone && (!out_valid || out_ready);
  // in_last on the final slot is just a normal block end.
  assign blk_end  = (fcnt == LAST_IDX) || in_last;

  // Fill control: index advances per accept, held once the block is complete.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt   <= '0;
      fdone  <= 1'b0;
      fscale <= '0;
    end else if (xfer) begin
      fcnt  <= '0;
      fdone <= 1'b0;
    end else if (accept) begin
      if (fcnt == '0) fscale <= in_scale;
      if (blk_end) fdone <= 1'b1;
      else         fcnt  <= fcnt + 1'b1;
    end
  end

  // Output handshake: transfer keeps out_valid high, a plain drain drops it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      scale_out <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      scale_out <= fscale;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  for (genvar g = 0; g < BLOCK_SIZE; g++) begin : g_lane
    mx_int8_pack_lane #(.ELEM_W(ELEM_W)) u_lane (
      .clk  (clk),
      .rst  (rst),
      .wr   (accept && (fcnt == CW'(g))),
      .xfer (xfer),
      .din  (in_data),
      .q    (elements_out[g])
    );
  end

`ifdef MXINT8_PACK_NAN_FLAG_EN
  localparam logic [ELEM_W-1:0] INT_NAN = {1'b1, {(ELEM_W-1){1'b0}}};
  logic fnan;

  // Sticky per-block flag: all-ones scale on the first element or any 0x80 element.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fnan    <= 1'b0;
      out_nan <= 1'b0;
    end else if (xfer) begin
      fnan    <= 1'b0;
      out_nan <= fnan;
    end else if (accept) begin
      if (fcnt == '0) fnan <= (&in_scale) || (in_data == INT_NAN);
      else            fnan <= fnan || (in_data == INT_NAN);
    end
  end
`endif
endmodule

// File: tb/tb_mx_int8_block_packer.sv
// Directed bench for mx_int8_block_packer (BLOCK_SIZE=32, int8, E8M0 scale).
module tb_mx_int8_block_packer;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, in_last;
  logic [7:0] in_data, in_scale;
  logic       out_valid, out_ready;
  logic [7:0] scale_out;
  logic [7:0] elements_out [31:0];
`ifdef MXINT8_PACK_NAN_FLAG_EN
  logic       out_nan;
`endif

  int checks = 0;
  int failures = 0;
  logic [7:0] expv [31:0];

  always #5 clk = ~clk;

  mx_int8_block_packer dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_scale     (in_scale),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .scale_out    (scale_out),
    .elements_out (elements_out)
`ifdef MXINT8_PACK_NAN_FLAG_EN
    ,
    .out_nan      (out_nan)
`endif
  );

  // Mismatching positions between elements_out and expv.
  function automatic int count_bad();
    int n = 0;
    for (int i = 0; i < 32; i++) if (elements_out[i] !== expv[i]) n++;
    return n;
  endfunction

  function automatic int first_bad();
    for (int i = 0; i < 32; i++) if (elements_out[i] !== expv[i]) return i;
    return -1;
  endfunction

  // Offer one element; called and returns 1 time unit after a posedge.
  task automatic push(input logic [7:0] d, input logic [7:0] s, input logic l);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_scale = s; in_last = l;
    while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL push_timeout in_ready stuck low, data=%h", d);
    end else begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (scale_out !== 8'h00) begin failures++; $display("FAIL reset_scale got=%h exp=00", scale_out); end
    for (int i = 0; i < 32; i++) expv[i] = 8'h00;
    checks++; if (count_bad() !== 0) begin failures++; $display("FAIL reset_elements bad=%0d first=%0d", count_bad(), first_bad()); end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    for (int i = 0; i < 32; i++) push(8'(i + 1), (i == 0) ? 8'h7F : 8'(i), 1'b0);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL basic_bubble in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%b exp=0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_out_valid got=%b exp=1", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL basic_in_ready_back got=%b exp=1", in_ready); end
    checks++; if (scale_out !== 8'h7F) begin failures++; $display("FAIL basic_scale got=%h exp=7f", scale_out); end
    for (int i = 0; i < 32; i++) expv[i] = 8'(i + 1);
    checks++; if (count_bad() !== 0) begin failures++; $display("FAIL basic_elements bad=%0d first=%0d", count_bad(), first_bad()); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_short_block();
    out_ready = 1'b1;
    // in_last without in_valid must not end anything.
    in_last = 1'b1; step(); step(); in_last = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL short_idle_last in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid); end
    for (int i = 0; i < 5; i++) push(8'hFF - 8'(i), 8'h80, i == 4);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL short_done in_ready got=%b exp=0", in_ready); end
    step();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL short_out_valid got=%b exp=1", out_valid); end
    checks++; if (scale_out !== 8'h80) begin failures++; $display("FAIL short_scale got=%h exp=80", scale_out); end
    expv[0] = 8'hFF; expv[1] = 8'hFE; expv[2] = 8'hFD; expv[3] = 8'hFC; expv[4] = 8'hFB;
    for (int i = 5; i < 32; i++) expv[i] = 8'h00;
    checks++; if (count_bad() !== 0) begin failures++; $display("FAIL short_elements bad=%0d first=%0d", count_bad(), first_bad()); end
    // Single-element block must land at index 0 with zero padding.
    push(8'h11, 8'h22, 1'b1);
    step();
    expv[0] = 8'h11;
    for (int i = 1; i < 32; i++) expv[i] = 8'h00;
    checks++; if (count_bad() !== 0 || scale_out !== 8'h22) begin
      failures++; $display("FAIL short_next_index0 bad=%0d scale=%h exp=22", count_bad(), scale_out); end
    step();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    for (int i = 0; i < 32; i++) push(8'h40 + 8'(i), (i == 0) ? 8'h01 : 8'hEE, 1'b0);
    for (int i = 0; i < 32; i++) push(8'h60 + 8'(i), (i == 0) ? 8'h02 : 8'hEE, 1'b0);
    step(); step(); step();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid got=%b exp=1", out_valid); end
    checks++; if (scale_out !== 8'h01) begin failures++; $display("FAIL bp_held_scale got=%h exp=01", scale_out); end
    for (int i = 0; i < 32; i++) expv[i] = 8'h40 + 8'(i);
    checks++; if (count_bad() !== 0) begin failures++; $display("FAIL bp_held_elements bad=%0d first=%0d", count_bad(), first_bad()); end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_no_bubble out_valid got=%b exp=1", out_valid); end
    checks++; if (scale_out !== 8'h02) begin failures++; $display("FAIL bp_second_scale got=%h exp=02", scale_out); end
    for (int i = 0; i < 32; i++) expv[i] = 8'h60 + 8'(i);
    checks++; if (count_bad() !== 0) begin failures++; $display("FAIL bp_second_elements bad=%0d first=%0d", count_bad(), first_bad()); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_in_ready_back got=%b exp=1", in_ready); end
    step();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_after got=%b exp=1", out_valid); end
    out_ready = 1'b1; step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_scale_sampling();
    out_ready = 1'b1;
    in_scale = 8'h99; step();
    // in_last on the final slot: must act as a single normal completion.
    for (int i = 0; i < 32; i++) push(8'(i) ^ 8'h5A, 8'h30 + 8'(i), i == 31);
    step();
    checks++; if (scale_out !== 8'h30) begin failures++; $display("FAIL scale_sample got=%h exp=30", scale_out); end
    for (int i = 0; i < 32; i++) expv[i] = 8'(i) ^ 8'h5A;
    checks++; if (count_bad() !== 0) begin failures++; $display("FAIL scale_elements bad=%0d first=%0d", count_bad(), first_bad()); end
    step();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL scale_single_completion out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready); end
  endtask

  task automatic test_reset_mid_block();
    out_ready = 1'b0;
    for (int i = 0; i < 32; i++) push(8'h20 + 8'(i), 8'h0C, 1'b0);
    for (int i = 0; i < 10; i++) push(8'hD0 + 8'(i), 8'h0D, 1'b0);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rstmid_pending got=%b exp=1", out_valid); end
    rst = 1'b1; #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_out_valid got=%b exp=0", out_valid); end
    for (int i = 0; i < 32; i++) expv[i] = 8'h00;
    checks++; if (count_bad() !== 0 || scale_out !== 8'h00) begin
      failures++; $display("FAIL rstmid_cleared bad=%0d scale=%h exp=00", count_bad(), scale_out); end
    @(posedge clk); #1; rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 32; i++) push(8'(3 * i), (i == 0) ? 8'h44 : 8'h0D, 1'b0);
    step();
    checks++; if (out_valid !== 1'b1 || scale_out !== 8'h44) begin
      failures++; $display("FAIL rstmid_clean_hdr out_valid=%b scale=%h exp 1/44", out_valid, scale_out); end
    for (int i = 0; i < 32; i++) expv[i] = 8'(3 * i);
    checks++; if (count_bad() !== 0) begin failures++; $display("FAIL rstmid_clean_elements bad=%0d first=%0d", count_bad(), first_bad()); end
    step();
  endtask

`ifdef MXINT8_PACK_NAN_FLAG_EN
  task automatic test_nan_flag();
    out_ready = 1'b1;
    for (int i = 0; i < 32; i++) push((i == 17) ? 8'h80 : 8'h05, 8'h10, 1'b0);
    step();
    checks++; if (out_nan !== 1'b1) begin failures++; $display("FAIL nan_elem got=%b exp=1", out_nan); end
    checks++; if (elements_out[17] !== 8'h80) begin failures++; $display("FAIL nan_passthru got=%h exp=80", elements_out[17]); end
    for (int i = 0; i < 32; i++) push(8'h06, (i == 0) ? 8'hFF : 8'h00, 1'b0);
    step();
    checks++; if (out_nan !== 1'b1 || scale_out !== 8'hFF) begin
      failures++; $display("FAIL nan_scale out_nan=%b scale=%h exp 1/ff", out_nan, scale_out); end
    for (int i = 0; i < 32; i++) push(8'h07, (i == 0) ? 8'h11 : 8'hFF, 1'b0);
    step();
    checks++; if (out_nan !== 1'b0) begin failures++; $display("FAIL nan_clear got=%b exp=0", out_nan); end
    step();
  endtask
`endif

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; in_scale = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    test_reset();
    test_basic();
    test_short_block();
    test_back_to_back();
    test_scale_sampling();
    test_reset_mid_block();
`ifdef MXINT8_PACK_NAN_FLAG_EN
    test_nan_flag();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout sim time exceeded");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mx_int8_block_packer.md
Name: mx_int8_block_packer

Overview:
- Upstream feeder for the MXINT8 block-sum unit.
- Accepts a serial stream of int8 elements, one per handshake. The shared E8M0 scale is captured with the first element of each block.
- Assembles complete BLOCK_SIZE-element MXINT8 vectors and presents them in parallel (scale plus element array) under a valid/ready handshake.
- Double-buffered: one fill buffer and one output register, so a new block fills while the previous one waits for the consumer.

Parameters:
- BLOCK_SIZE, 32, elements per MX block.
- ELEM_W, 8, MXINT8 element width (two's complement).
- SCALE_W, 8, E8M0 shared-scale width.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  stream element valid.
- in_ready  output  1  packer can accept an element.
- in_data  input  ELEM_W  stream element.
- in_scale  input  SCALE_W  block scale; sampled only on the accepted element with fill index 0.
- in_last  input  1  marks the final element of a short block; qualified by in_valid.
- out_valid  output  1  assembled block available.
- out_ready  input  1  consumer accepts the block.
- scale_out  output  SCALE_W  block scale.
- elements_out  output  ELEM_W x [BLOCK_SIZE-1:0] unpacked array  block elements; index 0 is the first streamed element.

Behaviour:
- Clock/reset are fixed: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset clears the following:
  - fill index fcnt=0, fill-done flag fdone=0, fill buffer to all 0;
  - out_valid=0, scale_out=0, all elements_out=0.
  - After reset, in_ready=1.
  - Reset asserted mid-block discards the partial block and any pending output block.
- in_ready = !fdone (combinational).
- Element accept is an edge where in_valid && in_ready:
  - in_data is written to fbuf[fcnt].
  - If fcnt==0, in_scale is captured into fscale.
  - If fcnt==BLOCK_SIZE-1 or in_last==1: fdone<=1 and fcnt is held. Otherwise fcnt<=fcnt+1.
- Transfer happens on an edge where fdone && (!out_valid || out_ready):
  - elements_out<=fbuf and scale_out<=fscale;
  - out_valid<=1, fdone<=0, fcnt<=0;
  - fbuf cleared to 0 in the same edge, so unwritten positions of a short block are emitted as 0.
- Output handshake:
  - Edge with out_valid && out_ready and no transfer: out_valid<=0.
  - Edge with out_valid && out_ready and a transfer: out_valid stays 1 with the new block (back-to-back, no bubble on the output side).
  - While out_valid && !out_ready: scale_out and elements_out are held stable.
- Latency: the last element is accepted on edge N; out_valid rises after edge N+1 if the output slot is free or draining.
- Throughput: full blocks take BLOCK_SIZE accepts plus 1 bubble cycle on in_ready per block.
- Stall: if the output is held, fdone stays 1 and in_ready stays 0 until the transfer.
- in_last on the element at fcnt==BLOCK_SIZE-1 is equivalent to a normal block end; there is no double completion.
- in_last while in_valid=0 is ignored.
- in_data / in_scale are not interpreted. 0x80 elements and a 0xFF scale pass through unchanged.
- fcnt width is $clog2(BLOCK_SIZE); no wrap occurs because fcnt is held at completion.

Optional Feature:
- Macro: MXINT8_PACK_NAN_FLAG_EN.
- Defined:
  - Adds output port out_nan, 1 bit.
  - out_nan is registered alongside scale_out and is valid with out_valid.
  - out_nan=1 if the block scale == all-ones (0xFF) or any accepted element == 0x80 (unused int8 code).
  - Tracked incrementally per accept in a sticky fnan bit, cleared on transfer and on reset.
  - Reset value 0. Zero-padded positions never set it.
- Undefined: no out_nan port and no fnan logic; behaviour is otherwise identical.

Test Plan:
- Basic block: reset, then stream 32 elements 1..32 with in_scale=0x7F on the first, out_ready=1 → out_valid rises 1 cycle after the 32nd accept; elements_out[i]=i+1, scale_out=0x7F; in_ready low for exactly 1 cycle.
- Short block: in_last on the 5th element (values -1,-2,-3,-4,-5), scale 0x80 → elements_out[0..4]=0xFF,0xFE,0xFD,0xFC,0xFB; [5..31]=0; the next block starts at index 0.
- Backpressure: out_ready=0 while two full blocks stream → first block held stable; in_ready=0 after the second completes. Raise out_ready for 1 cycle → second block appears the next cycle; out_valid never drops; in_ready returns to 1.
- Scale sampling: in_scale changes every cycle during a block → scale_out equals the value present on the index-0 accept only.
- Reset mid-block: assert rst after 10 accepts with a pending output → out_valid=0 and elements_out=0 immediately. The next 32 elements form a clean block with no residue from the discarded data.
- With MXINT8_PACK_NAN_FLAG_EN:
  - block with element[17]=0x80 → out_nan=1;
  - next block with scale 0xFF → out_nan=1;
  - next block, all normal → out_nan=0.
